// File: rtl/onchip_capture_mem.sv
// onchip_capture_mem
// Parametrised on-chip sample memory with two write sources:
//   - an Avalon-MM slave for the CPU (byte-lane writes, pipelined reads
//     with READ_LATENCY 1 or 2 and a readdatavalid strobe)
//   - a streaming port that fills the memory from the ADC front end,
//     either as a circular buffer or as a stop-when-full capture buffer.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   avs_address/byteenable/...     Avalon-MM slave (no waitrequest)
//   avs_readdata/readdatavalid     read return, valid READ_LATENCY cycles
//                                  after an accepted read
//   clken, reset_req               en = clken & ~reset_req; en low stalls all
//   st_valid/st_data/st_ready      ADC sample stream
//   cap_enable/cap_mode/cap_clear  capture control
//   wr_ptr/fill_count/full/overflow capture status
module onchip_capture_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic                    avs_chipselect,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_readdatavalid,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    st_valid,
  input  logic [DATA_WIDTH-1:0]   st_data,
  output logic                    st_ready,
  input  logic                    cap_enable,
  input  logic                    cap_mode,
  input  logic                    cap_clear,
  output logic [ADDR_WIDTH-1:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]     fill_count,
  output logic                    full,
  output logic                    overflow
);

  localparam int                NUM_LANES = DATA_WIDTH / 8;
  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic                  st_acc;
  logic                  ovf_set;
  logic [ADDR_WIDTH:0]   fill_next;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic                  rd_valid1;

  assign en     = clken & ~reset_req;
  assign cpu_wr = avs_chipselect & avs_write & en;
  assign cpu_rd = avs_chipselect & avs_read & en;

  // The CPU owns the single write port whenever it writes; the stream only
  // gets a slot when the CPU is not writing, and stop mode closes the gate
  // once the buffer is full.
  assign st_ready = en & cap_enable & ~cap_clear & ~(avs_chipselect & avs_write)
                    & ~(cap_mode & full);
  assign st_acc   = st_valid & st_ready;

  // Circular mode: an accepted sample while full overwrites the oldest one.
  // Stop mode: any offered sample while full is dropped. A sample held off
  // only by a CPU write is not lost, so it does not count.
  assign ovf_set = full & st_valid &
                   ((~cap_mode & st_ready) | (cap_mode & en & cap_enable));

  always_comb begin
    fill_next = fill_count;
    if (st_acc && !full) begin
      fill_next = fill_count + 1'b1;
    end
  end

  // Memory array: no reset so contents survive reset_n. The read register
  // sampling mem before this edge's write gives old-data on a collision.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (avs_byteenable[b]) begin
          mem[avs_address][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end else if (st_acc) begin
      mem[wr_ptr] <= st_data;
    end
  end

  // First read stage; holds its data between reads so readdata is stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
    end else if (en) begin
      rd_valid1 <= cpu_rd;
      if (cpu_rd) begin
        rd_data1 <= mem[avs_address];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_data2;
      logic                  rd_valid2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd_data2  <= '0;
          rd_valid2 <= 1'b0;
        end else if (en) begin
          rd_valid2 <= rd_valid1;
          if (rd_valid1) begin
            rd_data2 <= rd_data1;
          end
        end
      end

      assign avs_readdata      = rd_data2;
      assign avs_readdatavalid = rd_valid2;
    end else begin : g_lat1
      assign avs_readdata      = rd_data1;
      assign avs_readdatavalid = rd_valid1;
    end
  endgenerate

  // Capture state. full is registered from the next fill count so it always
  // agrees with fill_count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
    end else if (en) begin
      if (cap_clear) begin
        wr_ptr     <= '0;
        fill_count <= '0;
        full       <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (st_acc) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        fill_count <= fill_next;
        full       <= (fill_next == DEPTH_CNT);
        if (ovf_set) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_onchip_capture_mem.sv
// tb_onchip_capture_mem
// Drives two DEPTH=16 instances (READ_LATENCY 1 and 2) from shared inputs.
// Capture behaviour is table driven; reads, stalls and reset are hand
// sequences.
module tb_onchip_capture_mem;

  logic        clk;
  logic        reset_n;
  logic [3:0]  avs_address;
  logic [3:0]  avs_byteenable;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        clken;
  logic        reset_req;
  logic        st_valid;
  logic [31:0] st_data;
  logic        cap_enable;
  logic        cap_mode;
  logic        cap_clear;

  logic [31:0] r1_readdata, r2_readdata;
  logic        r1_valid, r2_valid;
  logic        r1_ready, r2_ready;
  logic [3:0]  r1_ptr, r2_ptr;
  logic [4:0]  r1_fill, r2_fill;
  logic        r1_full, r2_full;
  logic        r1_ovf, r2_ovf;

  int vectors_applied = 0;
  int miscompares     = 0;

  onchip_capture_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(r1_readdata),
    .avs_readdatavalid(r1_valid), .clken(clken), .reset_req(reset_req),
    .st_valid(st_valid), .st_data(st_data), .st_ready(r1_ready),
    .cap_enable(cap_enable), .cap_mode(cap_mode), .cap_clear(cap_clear),
    .wr_ptr(r1_ptr), .fill_count(r1_fill), .full(r1_full), .overflow(r1_ovf)
  );

  onchip_capture_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(r2_readdata),
    .avs_readdatavalid(r2_valid), .clken(clken), .reset_req(reset_req),
    .st_valid(st_valid), .st_data(st_data), .st_ready(r2_ready),
    .cap_enable(cap_enable), .cap_mode(cap_mode), .cap_clear(cap_clear),
    .wr_ptr(r2_ptr), .fill_count(r2_fill), .full(r2_full), .overflow(r2_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st_valid;
    logic [31:0] st_data;
    logic        cap_enable;
    logic        cap_mode;
    logic        cap_clear;
    logic        cpu_write;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        exp_ready;
    logic [3:0]  exp_ptr;
    logic [4:0]  exp_fill;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [46];

  function automatic vec_t mk(input int sv, input int sd, input int ce,
                              input int cm, input int cc, input int cw,
                              input int wa, input int wd, input int er,
                              input int ep, input int ef, input int efull,
                              input int eo);
    vec_t v;
    v.st_valid   = 1'(sv);
    v.st_data    = 32'(sd);
    v.cap_enable = 1'(ce);
    v.cap_mode   = 1'(cm);
    v.cap_clear  = 1'(cc);
    v.cpu_write  = 1'(cw);
    v.wr_addr    = 4'(wa);
    v.wr_data    = 32'(wd);
    v.exp_ready  = 1'(er);
    v.exp_ptr    = 4'(ep);
    v.exp_fill   = 5'(ef);
    v.exp_full   = 1'(efull);
    v.exp_ovf    = 1'(eo);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkCapture(input string tag, input logic [3:0] ptr,
                              input logic [4:0] fill, input logic fl,
                              input logic ovf);
    checkOutput({tag, " ptr1"},  32'(r1_ptr),  32'(ptr));
    checkOutput({tag, " ptr2"},  32'(r2_ptr),  32'(ptr));
    checkOutput({tag, " fill1"}, 32'(r1_fill), 32'(fill));
    checkOutput({tag, " fill2"}, 32'(r2_fill), 32'(fill));
    checkOutput({tag, " full1"}, 32'(r1_full), 32'(fl));
    checkOutput({tag, " full2"}, 32'(r2_full), 32'(fl));
    checkOutput({tag, " ovf1"},  32'(r1_ovf),  32'(ovf));
    checkOutput({tag, " ovf2"},  32'(r2_ovf),  32'(ovf));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    st_valid       = v.st_valid;
    st_data        = v.st_data;
    cap_enable     = v.cap_enable;
    cap_mode       = v.cap_mode;
    cap_clear      = v.cap_clear;
    avs_chipselect = v.cpu_write;
    avs_write      = v.cpu_write;
    avs_read       = 1'b0;
    avs_address    = v.wr_addr;
    avs_writedata  = v.wr_data;
    avs_byteenable = 4'hF;
    #2;
    checkOutput({tag, " ready1"}, 32'(r1_ready), 32'(v.exp_ready));
    checkOutput({tag, " ready2"}, 32'(r2_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    checkCapture(tag, v.exp_ptr, v.exp_fill, v.exp_full, v.exp_ovf);
  endtask

  task automatic idle();
    @(negedge clk);
    st_valid       = 1'b0;
    cap_enable     = 1'b0;
    cap_clear      = 1'b0;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_read       = 1'b0;
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(tbl[i], i);
    idle();
  endtask

  task automatic cpuWrite(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_read       = 1'b0;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    @(posedge clk);
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  // One isolated read: latency-1 instance answers after the first edge,
  // latency-2 instance after the second.
  task automatic readCheck(input logic [3:0] addr, input logic [31:0] exp);
    string tag;
    tag = $sformatf("rd[%0d]", addr);
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    avs_address    = addr;
    @(posedge clk);
    #1;
    checkOutput({tag, " valid1"}, 32'(r1_valid), 32'd1);
    checkOutput({tag, " data1"},  r1_readdata,   exp);
    checkOutput({tag, " early2"}, 32'(r2_valid), 32'd0);
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " valid2"}, 32'(r2_valid), 32'd1);
    checkOutput({tag, " data2"},  r2_readdata,   exp);
    checkOutput({tag, " drop1"},  32'(r1_valid), 32'd0);
    checkOutput({tag, " hold1"},  r1_readdata,   exp);
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    logic [31:0] pat [8];

    // Capture table
    tbl[0] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tbl[i] = mk(1, i, 1, 0, 0, 0, 0, 0, 1, i % 16, (i > 16) ? 16 : i,
                  (i >= 16) ? 1 : 0, (i > 16) ? 1 : 0);
    end
    tbl[21] = mk(1, 'h99, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tbl[21 + i] = mk(1, i, 1, 1, 0, 0, 0, 0, (i <= 16) ? 1 : 0,
                       (i < 16) ? i : 0, (i < 16) ? i : 16,
                       (i >= 16) ? 1 : 0, (i > 16) ? 1 : 0);
    end
    tbl[42] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[43] = mk(1, 'hAA, 1, 0, 0, 1, 9, 'h55, 0, 0, 0, 0, 0);
    tbl[44] = mk(1, 'hAA, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tbl[45] = mk(1, 'hBB, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    reset_n        = 1'b0;
    avs_address    = '0;
    avs_byteenable = '0;
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    clken          = 1'b1;
    reset_req      = 1'b0;
    st_valid       = 1'b0;
    st_data        = '0;
    cap_enable     = 1'b0;
    cap_mode       = 1'b0;
    cap_clear      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst data1",  r1_readdata,   32'd0);
    checkOutput("rst data2",  r2_readdata,   32'd0);
    checkOutput("rst valid1", 32'(r1_valid), 32'd0);
    checkOutput("rst valid2", 32'(r2_valid), 32'd0);
    checkCapture("rst", 4'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Byte-lane write then read back
    cpuWrite(4'd5, 32'hFFFF_FFFF, 4'hF);
    cpuWrite(4'd5, 32'hDEAD_BEEF, 4'b0011);
    readCheck(4'd5, 32'hFFFF_BEEF);

    // Back-to-back reads of 0..7
    for (int i = 0; i < 8; i++) begin
      pat[i] = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
      cpuWrite(4'(i), pat[i], 4'hF);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      avs_chipselect = 1'b1;
      avs_read       = (c < 8);
      avs_address    = 4'(c);
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b c%0d valid1", c), 32'(r1_valid), 32'(c < 8));
      if (c < 8) checkOutput($sformatf("b2b c%0d data1", c), r1_readdata, pat[c]);
      checkOutput($sformatf("b2b c%0d valid2", c), 32'(r2_valid),
                  32'(c >= 1 && c < 9));
      if (c >= 1 && c < 9)
        checkOutput($sformatf("b2b c%0d data2", c), r2_readdata, pat[c-1]);
    end
    idle();

    // Circular capture: 20 samples into 16 words
    runVectors(0, 20);
    readCheck(4'd0, 32'd17);
    readCheck(4'd3, 32'd20);
    readCheck(4'd4, 32'd5);

    // Stop-on-full capture
    runVectors(21, 41);
    readCheck(4'd15, 32'd16);
    readCheck(4'd0, 32'd1);

    // CPU write priority over a same-cycle sample
    runVectors(42, 45);
    readCheck(4'd0, 32'hAA);
    readCheck(4'd9, 32'h55);

    // Stall: reset_req freezes the read pipeline and the stream
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = 4'd0;
    @(posedge clk);
    #1;
    checkOutput("stall acc valid1", 32'(r1_valid), 32'd1);
    @(negedge clk);
    avs_read   = 1'b0;
    reset_req  = 1'b1;
    st_valid   = 1'b1;
    st_data    = 32'hCC;
    cap_enable = 1'b1;
    #2;
    checkOutput("stall ready1", 32'(r1_ready), 32'd0);
    checkOutput("stall ready2", 32'(r2_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("stall valid2", 32'(r2_valid), 32'd0);
    checkOutput("stall hold1",  32'(r1_valid), 32'd1);
    checkOutput("stall ptr1",   32'(r1_ptr),   32'd1);
    @(negedge clk);
    reset_req  = 1'b0;
    st_valid   = 1'b0;
    cap_enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resume valid2", 32'(r2_valid),  32'd1);
    checkOutput("resume data2",  r2_readdata,    32'hAA);
    checkOutput("resume valid1", 32'(r1_valid),  32'd0);
    idle();

    // Reset in the middle of a read and a capture
    applyStimulus(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    applyStimulus(mk(1, 'h31, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 101);
    applyStimulus(mk(1, 'h32, 1, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0), 102);
    applyStimulus(mk(1, 'h33, 1, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0), 103);
    @(negedge clk);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = 4'd1;
    st_valid       = 1'b1;
    st_data        = 32'h34;
    cap_enable     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    st_valid       = 1'b0;
    cap_enable     = 1'b0;
    reset_n        = 1'b0;
    #1;
    checkOutput("mid rst valid1", 32'(r1_valid), 32'd0);
    checkOutput("mid rst valid2", 32'(r2_valid), 32'd0);
    checkOutput("mid rst data1",  r1_readdata,   32'd0);
    checkCapture("mid rst", 4'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post rst c%0d valid1", c), 32'(r1_valid), 32'd0);
      checkOutput($sformatf("post rst c%0d valid2", c), 32'(r2_valid), 32'd0);
    end
    checkCapture("post rst", 4'd0, 5'd0, 1'b0, 1'b0);
    readCheck(4'd0, 32'h31);
    readCheck(4'd1, 32'h32);
    readCheck(4'd2, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
